// File: rtl/spi_slave_shifter_if.sv
// ---------------------------------------------------------------------------
// spi_slave_shifter_if
//   Bundles the SPI pins, mode controls and byte-side handshake of the
//   SPI slave shift engine into a single interface.
//
//   slave modport  : the shift engine itself (drives miso, miso_oe, tx_ready,
//                    rx_data, rx_valid, busy, overrun).
//   master modport : the environment (SPI master pins plus the register-file
//                    side that loads tx bytes and reads rx bytes).
//
//   Signals:
//     cpol, cpha, lsbfe      mode controls (quasi-static while selected)
//     ss_n, sclk_in, mosi    SPI pins from the master (asynchronous)
//     miso, miso_oe          SPI data out and its pad enable
//     tx_data, tx_load       byte for the next frame and its load strobe
//     tx_ready               tx buffer empty
//     rx_data, rx_valid      last received byte and its completion pulse
//     rx_rd                  consumer has read rx_data
//     busy, overrun          frame in progress / sticky overrun flag
// ---------------------------------------------------------------------------
interface spi_slave_shifter_if;
  logic       cpol;
  logic       cpha;
  logic       lsbfe;
  logic       ss_n;
  logic       sclk_in;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd;
  logic       busy;
  logic       overrun;

  modport slave (
    input  cpol, cpha, lsbfe, ss_n, sclk_in, mosi, tx_data, tx_load, rx_rd,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
  );

  modport master (
    output cpol, cpha, lsbfe, ss_n, sclk_in, mosi, tx_data, tx_load, rx_rd,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
  );
endinterface

// File: rtl/spi_slave_shifter.sv
// ---------------------------------------------------------------------------
// spi_slave_shifter
//   Slave-side SPI shift engine. Oversamples sclk_in, mosi and ss_n in the
//   PCLK domain, supports all four CPOL/CPHA modes and MSB/LSB-first order,
//   and exchanges one 8-bit frame per selection (or back-to-back frames while
//   ss_n stays low).
//
//   Ports:
//     PCLK     system clock, all logic on the rising edge
//     PRESETn  asynchronous active-low reset
//     bus      spi_slave_shifter_if.slave (pins, tx buffer, rx byte, status)
//
//   Parameters:
//     SYNC_STAGES  synchronizer depth on sclk_in/mosi/ss_n (2..3)
//
//   Optional feature macro:
//     SPI_SLAVE_OVERRUN_EN  enables rx_full tracking and the sticky overrun
//                           flag; when undefined overrun is tied low and
//                           rx_rd has no effect.
// ---------------------------------------------------------------------------
module spi_slave_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  spi_slave_shifter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  // Synchronizers plus one extra flop on sclk and ss for edge detection.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '1;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.ss_n};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  logic w_s_sclk, w_s_mosi, w_s_ss;
  logic w_sclk_rise, w_sclk_fall, w_lead, w_trail, w_sample, w_shift;
  logic w_ss_fall, w_ss_rise;

  assign w_s_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_s_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_s_ss      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_s_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_s_sclk & r_sclk_d;
  // Leading edge moves sclk away from its idle level, trailing returns to it.
  assign w_lead      = bus.cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = bus.cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = bus.cpha ? w_trail : w_lead;
  assign w_shift     = bus.cpha ? w_lead  : w_trail;
  assign w_ss_fall   = ~w_s_ss & r_ss_d;
  assign w_ss_rise   = w_s_ss & ~r_ss_d;

  state_t     r_state;
  logic       r_busy;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic       r_miso;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic [7:0] r_tx_buf;
  logic       r_tx_ready;

  // Frame start: fresh selection from IDLE, or back-to-back from COMPLETE.
  logic w_start;
  assign w_start = ((r_state == ST_IDLE) && w_ss_fall) ||
                   ((r_state == ST_COMPLETE) && !w_s_ss);

  // Byte consumed at frame start; an empty buffer sends zeros.
  logic [7:0] w_load_val, w_load_rest, w_tx_rest;
  logic       w_load_first, w_tx_head;
  assign w_load_val   = r_tx_ready ? 8'h00 : r_tx_buf;
  assign w_load_first = bus.lsbfe ? w_load_val[0] : w_load_val[7];
  assign w_load_rest  = bus.lsbfe ? {1'b0, w_load_val[7:1]} : {w_load_val[6:0], 1'b0};
  assign w_tx_head    = bus.lsbfe ? r_tx_shift[0] : r_tx_shift[7];
  assign w_tx_rest    = bus.lsbfe ? {1'b0, r_tx_shift[7:1]} : {r_tx_shift[6:0], 1'b0};

  // Receive register with the current sample merged in, so the completed
  // byte can be published on the same edge as the final sample.
  logic [2:0] w_rx_idx;
  logic [7:0] w_rx_next;
  assign w_rx_idx = bus.lsbfe ? r_bit_cnt : ~r_bit_cnt;

  always_comb begin
    w_rx_next           = r_rx_shift;
    w_rx_next[w_rx_idx] = w_s_mosi;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_miso     <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_buf   <= 8'h00;
      r_tx_ready <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;

      // A consume at frame start wins over a coincident load.
      if (w_start) begin
        r_tx_ready <= 1'b1;
      end else if (bus.tx_load && r_tx_ready) begin
        r_tx_buf   <= bus.tx_data;
        r_tx_ready <= 1'b0;
      end

      if (w_ss_rise) begin
        // Deselect always recovers to IDLE; a partial byte is dropped.
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_miso  <= 1'b0;
      end else if (w_start) begin
        r_state    <= ST_SHIFT;
        r_busy     <= 1'b1;
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
        // cpha=0 must present bit 0 before the first leading edge;
        // cpha=1 presents it on that edge instead.
        r_tx_shift <= bus.cpha ? w_load_val : w_load_rest;
        r_miso     <= bus.cpha ? 1'b0 : w_load_first;
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (w_sample) begin
              r_rx_shift <= w_rx_next;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
                r_state    <= ST_COMPLETE;
              end
            end else if (w_shift && (bus.cpha || (r_bit_cnt != 3'd0))) begin
              // With cpha=0 the trailing edge left over from the previous
              // back-to-back frame arrives before any sample and is ignored.
              r_miso     <= w_tx_head;
              r_tx_shift <= w_tx_rest;
            end
          end
          ST_COMPLETE: begin
            // Reached only when ss_n is already high; otherwise w_start fires.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_rx_full;
  logic r_overrun;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rx_full <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_rx_valid) begin
      // A read coinciding with a new byte acknowledges the old one only.
      r_rx_full <= 1'b1;
      r_overrun <= bus.rx_rd ? 1'b0 : (r_overrun | r_rx_full);
    end else if (bus.rx_rd) begin
      r_rx_full <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign bus.overrun = r_overrun;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.miso_oe  = ~w_s_ss;
  assign bus.miso     = ~w_s_ss & r_miso;
  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_shifter
//   Directed bench for spi_slave_shifter. A behavioural SPI master drives the
//   pins; expected rx bytes are queued when a frame is issued and a monitor
//   pops and compares them whenever rx_valid is seen.
// ---------------------------------------------------------------------------
module tb_spi_slave_shifter;
  localparam int HALF = 4;  // sclk half-period in PCLK cycles (PCLK/8)

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;

  spi_slave_shifter_if sif ();

  spi_slave_shifter #(.SYNC_STAGES(2)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (sif)
  );

  always #5 PCLK = ~PCLK;

  int         checks     = 0;
  int         errors     = 0;
  int         rx_pulses  = 0;
  int         busy_drops = 0;
  bit         watch_busy = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every rx_valid pulse must match the oldest queued byte.
  always @(negedge PCLK) begin
    if (PRESETn && sif.rx_valid === 1'b1) begin
      rx_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data %h, required no pulse", sif.rx_data);
      end else begin
        check8("rx_data", sif.rx_data, exp_q.pop_front());
        $display("rx byte %h", sif.rx_data);
      end
    end
    if (watch_busy && sif.busy !== 1'b1) busy_drops++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  function automatic int bpos(input int i);
    return sif.lsbfe ? i : 7 - i;
  endfunction

  task automatic load_tx(input logic [7:0] d);
    sif.tx_data = d;
    sif.tx_load = 1'b1;
    wait_clk(1);
    sif.tx_load = 1'b0;
  endtask

  task automatic pulse_rd();
    sif.rx_rd = 1'b1;
    wait_clk(1);
    sif.rx_rd = 1'b0;
    wait_clk(1);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    sif.cpol    = pol;
    sif.cpha    = pha;
    sif.lsbfe   = lsb;
    sif.sclk_in = pol;
    wait_clk(6);
  endtask

  // Master side of one frame (or nedges < 16 for a truncated one).
  task automatic xfer(input logic [7:0] mo, input int nedges, output logic [7:0] mi);
    int   i;
    logic lead;
    mi = 8'h00;
    if (sif.ss_n) begin
      sif.ss_n = 1'b0;
      wait_clk(6);
    end
    if (!sif.cpha) sif.mosi = mo[bpos(0)];
    wait_clk(HALF);
    for (int e = 0; e < nedges; e++) begin
      i    = e / 2;
      lead = (e % 2 == 0);
      if (lead != sif.cpha) mi[bpos(i)] = sif.miso;
      sif.sclk_in = lead ? ~sif.cpol : sif.cpol;
      if (sif.cpha && lead) sif.mosi = mo[bpos(i)];
      if (!sif.cpha && !lead && i < 7) sif.mosi = mo[bpos(i + 1)];
      wait_clk(HALF);
    end
    $display("frame mode=%0d%0d lsbfe=%0d mosi=%h miso=%h edges=%0d",
             sif.cpol, sif.cpha, sif.lsbfe, mo, mi, nedges);
  endtask

  task automatic end_frame();
    sif.ss_n    = 1'b1;
    sif.sclk_in = sif.cpol;
    wait_clk(8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check8({tag, "_miso"},     {7'b0, sif.miso},     8'h00);
    check8({tag, "_miso_oe"},  {7'b0, sif.miso_oe},  8'h00);
    check8({tag, "_tx_ready"}, {7'b0, sif.tx_ready}, 8'h01);
    check8({tag, "_rx_data"},  sif.rx_data,          8'h00);
    check8({tag, "_rx_valid"}, {7'b0, sif.rx_valid}, 8'h00);
    check8({tag, "_busy"},     {7'b0, sif.busy},     8'h00);
    check8({tag, "_overrun"},  {7'b0, sif.overrun},  8'h00);
  endtask

  logic [7:0] mi;
  int         p0;

  initial begin
    sif.cpol = 1'b0; sif.cpha = 1'b0; sif.lsbfe = 1'b0;
    sif.ss_n = 1'b1; sif.sclk_in = 1'b0; sif.mosi = 1'b1;
    sif.tx_data = 8'h00; sif.tx_load = 1'b0; sif.rx_rd = 1'b0;

    wait_clk(3);
    check_reset_outputs("reset");
    PRESETn = 1'b1;
    wait_clk(4);

    // Mode 0, MSB first: tx A5, master sends 3C.
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'hA5);
    check8("tx_ready_after_load", {7'b0, sif.tx_ready}, 8'h00);
    p0 = rx_pulses;
    exp_q.push_back(8'h3C);
    xfer(8'h3C, 16, mi);
    check8("mode0_miso", mi, 8'hA5);
    check8("mode0_tx_ready", {7'b0, sif.tx_ready}, 8'h01);
    check8("mode0_miso_oe", {7'b0, sif.miso_oe}, 8'h01);
    end_frame();
    check8("mode0_pulses", 8'(rx_pulses - p0), 8'h01);
    check8("deselect_miso_oe", {7'b0, sif.miso_oe}, 8'h00);

    // Modes 1..3, LSB first: tx 7E, master sends 81.
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b1);
      load_tx(8'h7E);
      exp_q.push_back(8'h81);
      xfer(8'h81, 16, mi);
      check8($sformatf("mode%0d_miso", m), mi, 8'h7E);
      end_frame();
    end

    // No tx_load: miso all zero, rx still correct.
    set_mode(1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    xfer(8'h5A, 16, mi);
    check8("empty_tx_miso", mi, 8'h00);
    end_frame();

    // Back-to-back frames with ss_n held low.
    p0 = rx_pulses;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    xfer(8'h11, 16, mi);
    watch_busy = 1'b1;
    xfer(8'h22, 16, mi);
    watch_busy = 1'b0;
    end_frame();
    check8("b2b_pulses", 8'(rx_pulses - p0), 8'h02);
    check8("b2b_busy_drops", 8'(busy_drops), 8'h00);
    check8("b2b_rx_data", sif.rx_data, 8'h22);

    // Abort after 5 sclk edges, then a full frame.
    p0 = rx_pulses;
    xfer(8'h96, 5, mi);
    end_frame();
    check8("abort_pulses", 8'(rx_pulses - p0), 8'h00);
    check8("abort_rx_data", sif.rx_data, 8'h22);
    check8("abort_busy", {7'b0, sif.busy}, 8'h00);
    exp_q.push_back(8'hF0);
    xfer(8'hF0, 16, mi);
    end_frame();

    // Overrun behaviour (or its absence in the default build).
    pulse_rd();
    check8("overrun_after_rd", {7'b0, sif.overrun}, 8'h00);
    exp_q.push_back(8'h55);
    xfer(8'h55, 16, mi);
    end_frame();
    check8("overrun_first", {7'b0, sif.overrun}, 8'h00);
    exp_q.push_back(8'hAA);
    xfer(8'hAA, 16, mi);
    end_frame();
    check8("overrun_rx_data", sif.rx_data, 8'hAA);
`ifdef SPI_SLAVE_OVERRUN_EN
    check8("overrun_set", {7'b0, sif.overrun}, 8'h01);
    pulse_rd();
    check8("overrun_cleared", {7'b0, sif.overrun}, 8'h00);
`else
    check8("overrun_tied_low", {7'b0, sif.overrun}, 8'h00);
`endif

    // Reset asserted mid-frame.
    load_tx(8'hFF);
    sif.ss_n = 1'b0;
    wait_clk(10);
    check8("prerst_busy", {7'b0, sif.busy}, 8'h01);
    check8("prerst_miso", {7'b0, sif.miso}, 8'h01);
    sif.sclk_in = 1'b1;
    wait_clk(2);
    PRESETn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wait_clk(2);
    sif.ss_n    = 1'b1;
    sif.sclk_in = 1'b0;
    wait_clk(2);
    PRESETn = 1'b1;
    wait_clk(10);

    check8("rx_queue_drained", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
